mil1553_rx_decoder: RTL and testbench
=====================================

Name: mil1553_rx_decoder

Overview:
- Receive-side MIL-STD-1553 Manchester decoder for the uart_1553 datapath, covering the opposite direction to the bench-side word encoder.
- Takes the differential pair rx0/rx1 at 1 Mbit/s.
- Detects command/status or data sync, then decodes 16 data bits plus odd parity.
- Presents each word on a single-register valid/ready output stream toward the UART framing logic.

Parameters:
- CLOCK_SPEED, 50000000, aclk frequency in Hz.
- BIT_RATE, 1000000, 1553 bit rate in Hz. CYCLES_PER_BIT = CLOCK_SPEED/BIT_RATE must be even and >= 8; elaboration fails otherwise.
- SYNC_TOL, 4, allowed +/- deviation in cycles for every measured sync half-period.

Ports:
- aclk  in  1  sole clock.
- arst  in  1  reset; synchronous, active-high.
- rx0_1553  in  1  true line of the differential pair, asynchronous.
- rx1_1553  in  1  complement line, asynchronous.
- m_tdata  out  16  decoded word, MSB received first.
- m_tuser  out  3  [0] sync type (1 = cmd/status, 0 = data); [1] parity error; [2] overflow (a word was dropped before this one).
- m_tvalid  out  1  word available.
- m_tready  in  1  consumer accepts.
- rx_active  out  1  high from sync start to word completion or abort.
- manchester_err  out  1  one-cycle pulse on any decode abort.

Behaviour:
- Inputs: each line passes through a 2-flop synchronizer.
  - Line state is valid only when rx0 != rx1.
  - Level = synchronized rx0.
  - rx0 == rx1 for more than CYCLES_PER_BIT/4 consecutive cycles during decode aborts the word.
- Encoding on level:
  - Cmd/status sync: 1.5 bit-times low, then 1.5 high.
  - Data sync: 1.5 high, then 1.5 low.
  - Logic 1: first half-bit low, second half high. Logic 0: the inverse.
  - Parity bit makes the 17-bit total odd.
- FSM states: IDLE, SYNC1, SYNC2, BITS, DONE.
  - IDLE -> SYNC1 on the first valid-state level change.
  - SYNC1 counts the first level. On the next level change, count within 1.5*CYCLES_PER_BIT +/- SYNC_TOL latches sync type and goes to SYNC2; otherwise return to IDLE silently (no error pulse).
  - SYNC2 counts the second level the same way. It ends at the mid-transition of bit 15; the first half of bit 15 may merge with the second sync level. On success go to BITS with the bit counter at 16; otherwise pulse manchester_err and go to IDLE.
  - BITS samples the level at 1/4 and 3/4 of each bit period.
    - The phase counter realigns to every detected mid-bit transition.
    - Equal samples: pulse manchester_err, go to IDLE.
    - Unequal samples: bit = second sample; shift into a 17-bit register. After the 17th bit, go to DONE.
  - DONE lasts one cycle. It computes parity_err = ~(^shift[16:0]) and loads the output register, then goes to IDLE.
- Output register:
  - m_tvalid rises the cycle after DONE, which is 2 cycles after the parity 3/4 sample.
  - The transfer completes on a cycle with m_tvalid && m_tready.
  - m_tvalid and m_tdata are held while m_tready is low.
  - If DONE occurs while the register still holds an unaccepted word, the new word overwrites it and m_tuser[2] is set. It clears on the next accepted word.
  - Simultaneous accept and DONE: the new word loads, overflow is not set, and m_tvalid stays high.
- Reset (arst high at any clock edge):
  - FSM to IDLE, counters cleared.
  - m_tdata = 0, m_tuser = 0, m_tvalid = 0, rx_active = 0, manchester_err = 0.
  - Synchronizers are loaded with rx0 = 0, rx1 = 1.
  - Reset mid-word discards the word with no error pulse.
- Consecutive words with no gap: the next sync may start immediately after the parity bit. IDLE detects its first edge in the cycle after DONE.

Optional Feature:
- MIL1553_RX_INVERT_EN defined: the roles of rx0_1553 and rx1_1553 swap after the synchronizers, supporting a transceiver with inverted polarity.
- Undefined: no swap, and no extra logic.

Decomposition:
- Package mil1553_pkg holds:
  - state enum (IDLE..DONE);
  - m_tuser bit-index constants;
  - sync level-order encodings;
  - the word length constant (17).
- One natural sub-module: mil1553_diff_sync, the 2-flop synchronizer plus valid-state/level outputs. Everything else stays in the top block.

Test Plan (50 MHz, 50 cycles/bit):
- Cmd sync + 0x0001 + parity 0, m_tready=1 -> m_tdata=0x0001, m_tuser=3'b001, m_tvalid for 1 cycle, 2 cycles after the parity sample.
- Data sync + 0xFFFF + parity 1 -> m_tdata=0xFFFF, m_tuser=3'b000.
- Cmd sync + 0x1234 with the parity bit flipped -> m_tdata=0x1234, m_tuser=3'b011.
- Bit 7 of 0xA5A5 sent with no mid-transition -> manchester_err pulse, no m_tvalid, rx_active low; the next clean word decodes correctly.
- m_tready=0, two back-to-back words 0x0002 then 0x0003 -> m_tdata=0x0003, m_tuser[2]=1; after accept, the next word has m_tuser[2]=0.
- Sync first half of 60 cycles (>75+4? no, <75-4) -> silent return to IDLE, no output. Also assert arst mid-word at bit 8 -> all outputs 0, and the following word decodes correctly.

Source files
------------

// File: rtl/mil1553_pkg.sv
// Shared types and constants for the MIL-STD-1553 receive decoder.
package mil1553_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC1,
        SYNC2,
        BITS,
        DONE
    } state_t;

    localparam int TUSER_SYNC = 0;
    localparam int TUSER_PERR = 1;
    localparam int TUSER_OVF  = 2;

    // {first level, second level} of the sync pattern
    localparam logic [1:0] SYNC_CMD  = 2'b01;
    localparam logic [1:0] SYNC_DATA = 2'b10;

    localparam int WORD_LEN = 17;

endpackage

// File: rtl/mil1553_diff_sync.sv
// Two-flop synchronizer for the 1553 differential pair, with line-state decode.
// Defining MIL1553_RX_INVERT_EN swaps the true/complement roles after sync.
module mil1553_diff_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rx0,
    input  logic i_rx1,
    output logic o_valid,
    output logic o_level
);

    logic [1:0] r_rx0;
    logic [1:0] r_rx1;
    logic       w_pos;
    logic       w_neg;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx0 <= 2'b00;
            r_rx1 <= 2'b11;
        end else begin
            r_rx0 <= {r_rx0[0], i_rx0};
            r_rx1 <= {r_rx1[0], i_rx1};
        end
    end

`ifdef MIL1553_RX_INVERT_EN
    assign w_pos = r_rx1[1];
    assign w_neg = r_rx0[1];
`else
    assign w_pos = r_rx0[1];
    assign w_neg = r_rx1[1];
`endif

    assign o_valid = w_pos ^ w_neg;
    assign o_level = w_pos;

endmodule

// File: rtl/mil1553_rx_decoder.sv
// MIL-STD-1553 Manchester receive decoder with a one-word valid/ready output.
// Optional MIL1553_RX_INVERT_EN swaps rx0/rx1 polarity (in mil1553_diff_sync).
module mil1553_rx_decoder #(
    parameter int CLOCK_SPEED = 50000000,
    parameter int BIT_RATE    = 1000000,
    parameter int SYNC_TOL    = 4
) (
    input  logic        aclk,
    input  logic        arst,
    input  logic        rx0_1553,
    input  logic        rx1_1553,
    output logic [15:0] m_tdata,
    output logic [2:0]  m_tuser,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        rx_active,
    output logic        manchester_err
);

    import mil1553_pkg::*;

    localparam int CPB = CLOCK_SPEED / BIT_RATE;
    localparam int CW  = $clog2(2 * CPB + SYNC_TOL + 2) + 1;

    generate
        if ((CPB % 2) != 0 || CPB < 8) begin : g_bad_rate
            $error("CYCLES_PER_BIT must be even and >= 8");
        end
    endgenerate

    localparam logic [CW-1:0] C_S_MIN = CW'(3 * CPB / 2 - SYNC_TOL);
    localparam logic [CW-1:0] C_S_MAX = CW'(3 * CPB / 2 + SYNC_TOL);
    localparam logic [CW-1:0] C_M_MIN = CW'(2 * CPB - SYNC_TOL);
    localparam logic [CW-1:0] C_M_MAX = CW'(2 * CPB + SYNC_TOL);
    localparam logic [CW-1:0] C_H_MIN = CW'(CPB / 2 - SYNC_TOL);
    localparam logic [CW-1:0] C_H_MAX = CW'(CPB / 2 + SYNC_TOL);
    localparam logic [CW-1:0] C_Q1    = CW'(CPB / 4);
    localparam logic [CW-1:0] C_Q3    = CW'(3 * CPB / 4);
    localparam logic [CW-1:0] C_HALF1 = CW'(CPB / 2 + 1);
    localparam logic [CW-1:0] C_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] C_INV   = CW'(CPB / 4);
    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [4:0]    C_NBITS = 5'(WORD_LEN - 1);

    state_t              r_state;
    state_t              w_state_n;
    logic                w_valid;
    logic                w_level;
    logic                r_prev_valid;
    logic                r_prev_level;
    logic                w_edge;
    logic                w_start;
    logic                w_inv_abort;
    logic                w_in_s;
    logic                w_in_m;
    logic                w_in_h;
    logic                w_abort;
    logic                w_shift_en;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       r_inv;
    logic [CW-1:0]       r_phase;
    logic [4:0]          r_bits;
    logic [WORD_LEN-1:0] r_shift;
    logic                r_s1;
    logic                r_s1val;
    logic                r_half;
    logic                r_first;
    logic                r_cmd;
    logic                r_err;
    logic [15:0]         r_tdata;
    logic [2:0]          r_tuser;
    logic                r_tvalid;

    mil1553_diff_sync u_sync (
        .i_clk   (aclk),
        .i_rst   (arst),
        .i_rx0   (rx0_1553),
        .i_rx1   (rx1_1553),
        .o_valid (w_valid),
        .o_level (w_level)
    );

    // Leaving the invalid line state also counts as a start in IDLE
    assign w_edge      = w_valid && (w_level != r_prev_level);
    assign w_start     = w_valid && (!r_prev_valid || (w_level != r_prev_level));
    assign w_inv_abort = !w_valid && (r_inv >= C_INV);
    assign w_in_s      = (r_cnt >= C_S_MIN) && (r_cnt <= C_S_MAX);
    assign w_in_m      = (r_cnt >= C_M_MIN) && (r_cnt <= C_M_MAX);
    assign w_in_h      = (r_cnt >= C_H_MIN) && (r_cnt <= C_H_MAX);

    always_ff @(posedge aclk) begin
        if (arst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_abort    = 1'b0;
        w_shift_en = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_n = SYNC1;
                end
            end
            SYNC1: begin
                if (w_inv_abort) begin
                    w_state_n = IDLE;
                end else if (w_edge) begin
                    if (w_in_s && (({r_first, w_level} == SYNC_CMD) ||
                                   ({r_first, w_level} == SYNC_DATA))) begin
                        w_state_n = SYNC2;
                    end else begin
                        w_state_n = IDLE;
                    end
                end else if (r_cnt > C_S_MAX) begin
                    w_state_n = IDLE;
                end
            end
            SYNC2: begin
                // Bit 15 is decoded here from its own mid-bit transition
                if (w_inv_abort) begin
                    w_abort = 1'b1;
                end else if (w_edge) begin
                    if (r_half ? w_in_h : w_in_m) begin
                        w_shift_en = 1'b1;
                        w_state_n  = BITS;
                    end else if (r_half || !w_in_s) begin
                        w_abort = 1'b1;
                    end
                end else if (r_cnt > (r_half ? C_H_MAX : C_M_MAX)) begin
                    w_abort = 1'b1;
                end
            end
            BITS: begin
                if (w_inv_abort) begin
                    w_abort = 1'b1;
                end else if (r_s1 && (r_phase == C_Q3)) begin
                    if (r_s1val == w_level) begin
                        w_abort = 1'b1;
                    end else begin
                        w_shift_en = 1'b1;
                        if (r_bits == 5'd1) begin
                            w_state_n = DONE;
                        end
                    end
                end
            end
            DONE: begin
                w_state_n = IDLE;
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
        if (w_abort) begin
            w_state_n = IDLE;
        end
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            r_prev_valid <= 1'b1;
            r_prev_level <= 1'b0;
            r_inv        <= '0;
            r_cnt        <= '0;
            r_phase      <= '0;
            r_bits       <= '0;
            r_shift      <= '0;
            r_s1         <= 1'b0;
            r_s1val      <= 1'b0;
            r_half       <= 1'b0;
            r_first      <= 1'b0;
            r_cmd        <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_prev_valid <= w_valid;
            if (w_valid) begin
                r_prev_level <= w_level;
            end
            if (w_valid) begin
                r_inv <= '0;
            end else if (r_inv != '1) begin
                r_inv <= r_inv + C_ONE;
            end
            if ((r_state == IDLE) ? w_start : w_edge) begin
                r_cnt <= C_ONE;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + C_ONE;
            end
            if ((r_state == IDLE) && w_start) begin
                r_first <= w_level;
            end
            if ((r_state == SYNC1) && w_edge) begin
                r_cmd <= ({r_first, w_level} == SYNC_CMD);
            end
            if (r_state != SYNC2) begin
                r_half <= 1'b0;
            end else if (w_edge) begin
                r_half <= 1'b1;
            end
            // Realign only on mid-bit edges, never on bit-boundary edges
            if (w_edge && ((r_state == SYNC2) ||
                           ((r_state == BITS) && r_s1))) begin
                r_phase <= C_HALF1;
            end else if (r_phase >= C_LAST) begin
                r_phase <= '0;
            end else begin
                r_phase <= r_phase + C_ONE;
            end
            if (r_state != BITS) begin
                r_s1 <= 1'b0;
            end else if (r_phase == C_Q1) begin
                r_s1    <= 1'b1;
                r_s1val <= w_level;
            end else if (r_phase == C_Q3) begin
                r_s1 <= 1'b0;
            end
            if (w_shift_en) begin
                r_shift <= {r_shift[WORD_LEN-2:0], w_level};
            end
            if (r_state == SYNC2) begin
                r_bits <= C_NBITS;
            end else if (w_shift_en) begin
                r_bits <= r_bits - 5'd1;
            end
            r_err <= w_abort;
        end
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            r_tdata  <= '0;
            r_tuser  <= '0;
            r_tvalid <= 1'b0;
        end else if (r_state == DONE) begin
            r_tdata             <= r_shift[WORD_LEN-1:1];
            r_tuser[TUSER_SYNC] <= r_cmd;
            r_tuser[TUSER_PERR] <= ~(^r_shift);
            r_tuser[TUSER_OVF]  <= r_tvalid && !m_tready;
            r_tvalid            <= 1'b1;
        end else if (m_tready) begin
            r_tvalid <= 1'b0;
        end
    end

    assign m_tdata        = r_tdata;
    assign m_tuser        = r_tuser;
    assign m_tvalid       = r_tvalid;
    assign rx_active      = (r_state != IDLE);
    assign manchester_err = r_err;

endmodule

// File: tb/tb_mil1553_rx_decoder.sv
// Scoreboard bench for mil1553_rx_decoder at 50 MHz / 1 Mbit/s.
module tb_mil1553_rx_decoder;

    logic        aclk = 1'b0;
    logic        arst = 1'b1;
    logic        rx0  = 1'b0;
    logic        rx1  = 1'b0;
    logic        rdy  = 1'b1;
    logic [15:0] m_tdata;
    logic [2:0]  m_tuser;
    logic        m_tvalid;
    logic        rx_active;
    logic        manchester_err;

    typedef struct packed {
        logic [15:0] d;
        logic [2:0]  u;
    } exp_t;

    exp_t sb[$];
    int   checks     = 0;
    int   errors     = 0;
    int   err_pulses = 0;
    int   p0;

    mil1553_rx_decoder dut (
        .aclk           (aclk),
        .arst           (arst),
        .rx0_1553       (rx0),
        .rx1_1553       (rx1),
        .m_tdata        (m_tdata),
        .m_tuser        (m_tuser),
        .m_tvalid       (m_tvalid),
        .m_tready       (rdy),
        .rx_active      (rx_active),
        .manchester_err (manchester_err)
    );

    always #10 aclk = ~aclk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_word(input logic [15:0] d, input logic [2:0] u);
        exp_t e;
        e.d = d;
        e.u = u;
        sb.push_back(e);
    endtask

    // lvl 0/1 drives a valid level; 2 drives the invalid (idle) state
    task automatic line(input int lvl, input int n);
        if (lvl == 2) begin
            rx0 = 1'b0;
            rx1 = 1'b0;
        end else begin
            rx0 = lvl[0];
            rx1 = !lvl[0];
        end
        repeat (n) @(negedge aclk);
    endtask

    task automatic send_word(input bit cmd, input logic [15:0] d,
                             input bit flip, input int bad);
        logic [16:0] w;
        w = {d, ~(^d) ^ flip};
        if (cmd) begin
            line(0, 75);
            line(1, 75);
        end else begin
            line(1, 75);
            line(0, 75);
        end
        for (int i = 16; i >= 0; i--) begin
            if (i >= 1 && (i - 1) == bad) begin
                line(int'(w[i]), 50);
            end else begin
                line(int'(!w[i]), 25);
                line(int'(w[i]), 25);
            end
        end
    endtask

    task automatic set_ready(input logic v);
        @(posedge aclk);
        #2;
        rdy = v;
    endtask

    task automatic drained(input string name);
        chk(name, 32'(sb.size()), 32'd0);
    endtask

    always @(negedge aclk) begin : mon
        exp_t e;
        if (manchester_err) begin
            err_pulses++;
        end
        if (m_tvalid && rdy) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got data 0x%0h user %b, expected none",
                         m_tdata, m_tuser);
            end else begin
                e = sb.pop_front();
                chk("tdata", 32'(m_tdata), 32'(e.d));
                chk("tuser", 32'(m_tuser), 32'(e.u));
            end
        end
    end

    initial begin
        repeat (4) @(negedge aclk);
        chk("rst_tdata", 32'(m_tdata), 32'd0);
        chk("rst_tuser", 32'(m_tuser), 32'd0);
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_active", 32'(rx_active), 32'd0);
        chk("rst_err", 32'(manchester_err), 32'd0);
        arst = 1'b0;
        line(2, 20);

        expect_word(16'h0001, 3'b001);
        send_word(1'b1, 16'h0001, 1'b0, -1);
        line(2, 20);
        drained("t1_drained");

        expect_word(16'hFFFF, 3'b000);
        send_word(1'b0, 16'hFFFF, 1'b0, -1);
        line(2, 20);
        drained("t2_drained");

        expect_word(16'h1234, 3'b011);
        send_word(1'b1, 16'h1234, 1'b1, -1);
        line(2, 20);
        drained("t3_drained");

        p0 = err_pulses;
        send_word(1'b1, 16'hA5A5, 1'b0, 7);
        line(2, 20);
        chk("t4_err_pulses", 32'(err_pulses - p0), 32'd1);
        chk("t4_active", 32'(rx_active), 32'd0);
        expect_word(16'hA5A5, 3'b001);
        send_word(1'b1, 16'hA5A5, 1'b0, -1);
        line(2, 20);
        drained("t4_drained");

        set_ready(1'b0);
        expect_word(16'h0003, 3'b100);
        send_word(1'b0, 16'h0002, 1'b0, -1);
        send_word(1'b0, 16'h0003, 1'b0, -1);
        line(2, 20);
        chk("t5_held_valid", 32'(m_tvalid), 32'd1);
        chk("t5_held_data", 32'(m_tdata), 32'h0003);
        set_ready(1'b1);
        line(2, 5);
        drained("t5_drained");
        expect_word(16'h0004, 3'b001);
        send_word(1'b1, 16'h0004, 1'b0, -1);
        line(2, 20);
        drained("t5_next_drained");

        p0 = err_pulses;
        line(0, 60);
        line(1, 75);
        line(2, 20);
        chk("t6_err_pulses", 32'(err_pulses - p0), 32'd0);
        chk("t6_active", 32'(rx_active), 32'd0);
        chk("t6_tvalid", 32'(m_tvalid), 32'd0);

        set_ready(1'b0);
        send_word(1'b1, 16'h5A5A, 1'b0, -1);
        line(2, 20);
        chk("t7_pending_valid", 32'(m_tvalid), 32'd1);
        chk("t7_pending_data", 32'(m_tdata), 32'h5A5A);
        p0 = err_pulses;
        fork
            send_word(1'b1, 16'h3C3C, 1'b0, -1);
            begin
                repeat (510) @(negedge aclk);
                chk("t7_active_mid", 32'(rx_active), 32'd1);
                arst = 1'b1;
                @(negedge aclk);
                chk("t7_rst_tdata", 32'(m_tdata), 32'd0);
                chk("t7_rst_tuser", 32'(m_tuser), 32'd0);
                chk("t7_rst_tvalid", 32'(m_tvalid), 32'd0);
                chk("t7_rst_active", 32'(rx_active), 32'd0);
                chk("t7_rst_err", 32'(manchester_err), 32'd0);
                arst = 1'b0;
            end
        join
        line(2, 20);
        chk("t7_err_pulses", 32'(err_pulses - p0), 32'd0);
        set_ready(1'b1);
        line(2, 5);
        expect_word(16'h00FF, 3'b000);
        send_word(1'b0, 16'h00FF, 1'b0, -1);
        line(2, 20);
        drained("t7_drained");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
